// File: rtl/crc_pkg.sv
// Shared CRC-8 constants and the single-bit step function used by the serial
// CRC block, the receiver and any transmitter-side model.
package crc_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One MSB-first LFSR step; poly omits the implicit x^8 term.
  function automatic logic [7:0] crc8_step(
    input logic [7:0] crc,
    input logic       din,
    input logic [7:0] poly = CRC8_POLY
  );
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial_if.sv
// Signal bundle for driving a crc8_serial instance: bit stream in, remainder out.
interface crc8_serial_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             din;
  logic [WIDTH-1:0] crc_out;

  // No handshake: a bit is consumed on every rising clk edge with en high;
  // crc_out reflects it after that edge and holds while en is low.
  modport master (output en, output din, input crc_out);
  modport slave  (input en, input din, output crc_out);

endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC generator/checker: one message bit (MSB first) per enabled
// clock, remainder exposed straight from the register.
module crc8_serial
  import crc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC8_POLY),
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(CRC8_INIT)
) (
  input  logic             en,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [WIDTH-1:0] crc_out
);

  logic [WIDTH-1:0] crc_next;

  // The 8-bit case shares the package step; other widths use the same rule inline.
  generate
    if (WIDTH == 8) begin : g_crc8
      always_comb begin
        crc_next = crc8_step(crc_out, din, POLY);
      end
    end else begin : g_generic
      always_comb begin
        crc_next = {crc_out[WIDTH-2:0], 1'b0} ^ ((crc_out[WIDTH-1] ^ din) ? POLY : '0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_out <= INIT;
    end else if (en) begin
      crc_out <= crc_next;
    end
  end

endmodule

// File: tb/tb_crc8_serial.sv
// Randomised scoreboard bench for crc8_serial against a polynomial long-division model.
module tb_crc8_serial;

  logic clk;
  logic rst_n;

  crc8_serial_if #(.WIDTH(8)) bus ();

  crc8_serial #(.WIDTH(8)) dut (
    .en      (bus.en),
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (bus.din),
    .crc_out (bus.crc_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got=running want=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  bit         hist[$];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%02h want=%02h", name, act, exp);
    end
  endtask

  task automatic check_nonzero(input string name, input logic [7:0] act);
    total++;
    if (act === 8'h00 || $isunknown(act)) begin
      bad++;
      $display("FAIL %s got=%02h want=nonzero", name, act);
    end
  endtask

  // Reference: remainder of M(x)*x^8 divided by x^8+x^2+x+1, by long division.
  function automatic logic [7:0] ref_crc(input bit msg[$]);
    bit         m[$];
    logic [8:0] g;
    logic [7:0] r;
    int         n;
    g = 9'h107;
    m = msg;
    n = m.size();
    for (int k = 0; k < 8; k++) m.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (m[i]) begin
        for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ g[8-j];
      end
    end
    for (int k = 0; k < 8; k++) r[7-k] = m[n+k];
    return r;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        #1;
        e = exp_q.pop_front();
        check("scoreboard", bus.crc_out, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input bit e, input bit d);
    @(negedge clk);
    bus.en  = e;
    bus.din = d;
    if (e) hist.push_back(d);
    exp_q.push_back(ref_crc(hist));
  endtask

  task automatic drive_gap(input int lo, input int hi);
    int n;
    n = $urandom_range(hi, lo);
    repeat (n) drive_bit(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic feed_byte(input logic [7:0] b, input int lo, input int hi);
    for (int i = 7; i >= 0; i--) begin
      drive_gap(lo, hi);
      drive_bit(1'b1, b[i]);
    end
  endtask

  task automatic wait_idle();
    @(posedge clk);
    #2;
    bus.en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    bus.en  = 1'b1;
    bus.din = 1'b1;
    #1;
    check("async_reset", bus.crc_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_with_en", bus.crc_out, 8'h00);
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b0;
    hist.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  str[9];
    logic [7:0]  cap;
    logic [11:0] frame;
    logic [11:0] bad_frame;
    int          nbits;

    str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst_n   = 1'b0;
    bus.en  = 1'b1;
    bus.din = 1'b1;
    #1;
    check("reset_state", bus.crc_out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state_clocked", bus.crc_out, 8'h00);
    @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b0;

    // single bits
    drive_bit(1'b1, 1'b1);
    wait_idle();
    check("single_one", bus.crc_out, 8'h07);
    do_reset();
    drive_bit(1'b1, 1'b0);
    wait_idle();
    check("single_zero", bus.crc_out, 8'h00);

    // known bytes
    do_reset(); feed_byte(8'h01, 0, 0); wait_idle();
    check("byte_01", bus.crc_out, 8'h07);
    do_reset(); feed_byte(8'h80, 0, 0); wait_idle();
    check("byte_80", bus.crc_out, 8'h89);
    do_reset(); feed_byte(8'hFF, 0, 0); wait_idle();
    check("byte_ff", bus.crc_out, 8'hF3);
    do_reset();
    for (int i = 0; i < 9; i++) feed_byte(str[i], 0, 0);
    wait_idle();
    check("check_string", bus.crc_out, 8'hF4);

    // enable gating with random din while disabled
    do_reset(); feed_byte(8'hFF, 3, 3); wait_idle();
    check("gated_ff", bus.crc_out, 8'hF3);

    // frame self-check: 4-bit size then data byte, then the CRC itself
    frame = {4'b0001, 8'hA5};
    do_reset();
    for (int i = 11; i >= 0; i--) drive_bit(1'b1, frame[i]);
    wait_idle();
    cap = bus.crc_out;
    for (int i = 7; i >= 0; i--) drive_bit(1'b1, cap[i]);
    wait_idle();
    check("frame_residue", bus.crc_out, 8'h00);
    for (int p = 0; p < 12; p++) begin
      bad_frame = frame ^ (12'h001 << p);
      do_reset();
      for (int i = 11; i >= 0; i--) drive_bit(1'b1, bad_frame[i]);
      for (int i = 7; i >= 0; i--) drive_bit(1'b1, cap[i]);
      wait_idle();
      check_nonzero("frame_flip", bus.crc_out);
    end

    // mid-message reset
    do_reset();
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'($urandom_range(0, 1)));
    wait_idle();
    do_reset();
    feed_byte(8'h01, 0, 0);
    wait_idle();
    check("after_mid_reset", bus.crc_out, 8'h07);

    // random streams with random enable gaps
    for (int t = 0; t < 25; t++) begin
      do_reset();
      nbits = $urandom_range(40, 1);
      for (int i = 0; i < nbits; i++) begin
        drive_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      wait_idle();
    end

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc8_serial.md
# crc8_serial

Bit-serial CRC-8 generator/checker for the UART-style frame receiver. Each enabled clock shifts one message bit (MSB first) through an 8-bit LFSR. The running remainder is exposed in parallel so the receiver can compare it, bit by bit, against the CRC byte that follows the frame-size and data fields. One instance per receiver. It is cleared between frames by reset.

## Interface
Parameters:
- `WIDTH`, default 8: CRC register width; only 8 is required and verified.
- `POLY`, default 8'h07: generator polynomial x^8+x^2+x+1, with the implicit x^8 term omitted.
- `INIT`, default 8'h00: register value after reset.

Ports (clock and reset listed first):
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: when high at a rising edge, consume `din`.
- `din`, input, 1: next message bit, MSB of each field first.
- `crc_out`, output, WIDTH: current CRC remainder, driven directly from the register.

Positional port order of the module declaration is fixed: `en, clk, rst_n, din, crc_out`. Existing positional instantiations depend on it.

## Operation
- Algorithm: CRC-8, polynomial 0x07, init 0x00, no input/output reflection, no final XOR. Result is identical to CRC-8/SMBUS.
- Per enabled bit:
  - fb = crc[7] XOR din.
  - crc_next = {crc[6:0], 1'b0} XOR (fb ? POLY : 0).
- `en` low: register holds its value; `din` is ignored.
- No internal bit or field counter. The block is agnostic to frame length and processes any number of bits.
- Checker usage:
  - Feed all protected bits (4-bit frame size, then data bytes).
  - `crc_out[7]` down to `crc_out[0]` then equals the transmitted CRC bits in arrival order.
  - `en` must stay low while the CRC bits themselves arrive. Otherwise the register changes during comparison.
- Alternative checker usage: enable across the CRC bits as well. A correct frame then leaves `crc_out` == 8'h00.

## Timing
- Reset:
  - `rst_n` low immediately and asynchronously forces `crc_out` = INIT (8'h00), regardless of `clk`/`en`.
  - Release is synchronous in effect: the first update occurs at the first rising edge with `rst_n` high and `en` high.
- Latency: one cycle. The bit sampled at edge N is reflected in `crc_out` after edge N.
- `en` high on consecutive cycles processes one bit per cycle. There is no throughput restriction.
- Reset asserted mid-message: the partial remainder is discarded. Resuming after release restarts from INIT.
- `rst_n` low and `en` high simultaneously: reset wins, and the register stays INIT.
- No handshake and no busy/ready signal.
- The output is purely registered, with no combinational path from `din` or `en` to `crc_out`.

## Structure
- Shared package `crc_pkg` holds:
  - `CRC8_POLY = 8'h07` and `CRC8_INIT = 8'h00`.
  - A pure function `crc8_step(crc, din)` returning the next remainder. The receiver and any transmitter/bench model reuse it.
- The block is a single `always_ff` register plus the step function. No sub-module.
- Optional: a `WIDTH`-generic version of the step loop in the package, for future CRC-16 reuse.

## Test plan
- Reset: drive `rst_n` = 0 asynchronously mid-cycle → `crc_out` == 8'h00 before the next clock edge. With `en` = 1 during reset, it stays 8'h00.
- Single bit: reset, then one enabled `din` = 1 → `crc_out` == 8'h07. One enabled `din` = 0 from reset → 8'h00.
- Bytes MSB-first from reset:
  - 0x01 → 8'h07.
  - 0x80 → 8'h89.
  - 0xFF → 8'hF3.
  - ASCII "123456789" (72 bits) → 8'hF4.
- Enable gating: feed 0xFF with `en` toggled low for 3 random cycles between bits, with random `din` while low → `crc_out` still 8'hF3.
- Frame self-check: feed 4-bit size 4'b0001 plus data byte 0xA5. Capture `crc_out`, then feed those 8 CRC bits with `en` high → final `crc_out` == 8'h00. Flip any one data bit → final value is nonzero.
- Mid-message reset: feed 5 bits, pulse `rst_n` low, then feed 0x01 → 8'h07.
